// File: rtl/l2_line_arbiter.sv
// Arbitrates the single line-wide L2 port between the I-cache and the D-cache.
// One transaction in flight at a time; saturating per-requester grant counters.
module l2_line_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32,
  parameter bit FAIR       = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  icache_read,
  input  logic [ADDR_WIDTH-1:0] icache_address,
  output logic [LINE_WIDTH-1:0] icache_rdata,
  output logic                  icache_resp,
  input  logic                  dcache_read,
  input  logic                  dcache_write,
  input  logic [ADDR_WIDTH-1:0] dcache_address,
  input  logic [LINE_WIDTH-1:0] dcache_wdata,
  output logic [LINE_WIDTH-1:0] dcache_rdata,
  output logic                  dcache_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  output logic [31:0]           icache_grants,
  output logic [31:0]           dcache_grants
);

  typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY} state_t;

  state_t state;
  state_t state_next;
  logic   last_grant_d;
  logic   we;
  logic   d_req;
  logic   grant_i;
  logic   grant_d;
  logic   busy_i;
  logic   busy_d;

  // A read+write collision from the D-cache is treated as a write.
  assign d_req = dcache_read | dcache_write;

  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    case (state)
      IDLE: begin
        if (icache_read && d_req) begin
          if (FAIR && last_grant_d) grant_i = 1'b1;
          else                      grant_d = 1'b1;
        end else if (icache_read) begin
          grant_i = 1'b1;
        end else if (d_req) begin
          grant_d = 1'b1;
        end
        if (grant_i) state_next = I_BUSY;
        if (grant_d) state_next = D_BUSY;
      end
      I_BUSY, D_BUSY: begin
        if (mem_resp) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      last_grant_d  <= 1'b1;
      we            <= 1'b0;
      mem_address   <= '0;
      mem_wdata     <= '0;
      icache_grants <= '0;
      dcache_grants <= '0;
    end else begin
      state <= state_next;
      if (grant_i) begin
        mem_address  <= icache_address;
        we           <= 1'b0;
        last_grant_d <= 1'b0;
        if (icache_grants != '1) icache_grants <= icache_grants + 32'd1;
      end
      if (grant_d) begin
        mem_address  <= dcache_address;
        mem_wdata    <= dcache_wdata;
        we           <= dcache_write;
        last_grant_d <= 1'b1;
        if (dcache_grants != '1) dcache_grants <= dcache_grants + 32'd1;
      end
    end
  end

  // Strobes come from registered state; responses are combinational on mem_resp.
  assign busy_i       = (state == I_BUSY);
  assign busy_d       = (state == D_BUSY);
  assign mem_read     = busy_i | (busy_d & ~we);
  assign mem_write    = busy_d & we;
  assign icache_resp  = busy_i & mem_resp;
  assign dcache_resp  = busy_d & mem_resp;
  assign icache_rdata = mem_rdata;
  assign dcache_rdata = mem_rdata;

endmodule

// File: tb/tb_l2_line_arbiter.sv
// Scoreboard bench for l2_line_arbiter: lane 0 is round-robin, lane 1 fixed priority.
`timescale 1ns/1ps
module tb_l2_line_arbiter;
  localparam int LW = 256;
  localparam int AW = 32;
  typedef logic [LW-1:0] line_t;

  typedef struct {
    int          lane;
    logic        we;
    logic [AW-1:0] addr;
    line_t       wdata;
  } grant_t;

  typedef struct {
    int    lane;
    logic  is_d;
    int    cycles;
    line_t data;
  } resp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [1:0]    icache_read, dcache_read, dcache_write;
  logic [1:0]    icache_resp, dcache_resp, mem_read, mem_write, mem_resp, manual_resp;
  logic [AW-1:0] icache_address [2];
  logic [AW-1:0] dcache_address [2];
  logic [AW-1:0] mem_address [2];
  line_t         dcache_wdata [2];
  line_t         mem_wdata [2];
  line_t         icache_rdata [2];
  line_t         dcache_rdata [2];
  logic [31:0]   icache_grants [2];
  logic [31:0]   dcache_grants [2];
  line_t         mem_rdata;
  bit            resp_en;
  int            lat;

  grant_t exp_grant[$];
  resp_t  exp_resp[$];
  int     checks = 0;
  int     errors = 0;

  function automatic void check(input string name, input line_t act, input line_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endfunction

  task automatic exp_g(input int l, input logic w, input logic [AW-1:0] a, input line_t wd);
    grant_t g;
    g.lane = l; g.we = w; g.addr = a; g.wdata = wd;
    exp_grant.push_back(g);
  endtask

  task automatic exp_r(input int l, input logic d, input int cyc, input line_t dat);
    resp_t r;
    r.lane = l; r.is_d = d; r.cycles = cyc; r.data = dat;
    exp_resp.push_back(r);
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_lane
    logic auto_resp;
    assign mem_resp[gi] = auto_resp | manual_resp[gi];

    l2_line_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW), .FAIR(gi == 0)) dut (
      .clk(clk), .rst(rst),
      .icache_read(icache_read[gi]), .icache_address(icache_address[gi]),
      .icache_rdata(icache_rdata[gi]), .icache_resp(icache_resp[gi]),
      .dcache_read(dcache_read[gi]), .dcache_write(dcache_write[gi]),
      .dcache_address(dcache_address[gi]), .dcache_wdata(dcache_wdata[gi]),
      .dcache_rdata(dcache_rdata[gi]), .dcache_resp(dcache_resp[gi]),
      .mem_read(mem_read[gi]), .mem_write(mem_write[gi]),
      .mem_address(mem_address[gi]), .mem_wdata(mem_wdata[gi]),
      .mem_rdata(mem_rdata), .mem_resp(mem_resp[gi]),
      .icache_grants(icache_grants[gi]), .dcache_grants(dcache_grants[gi])
    );

    // L2 model: answers on the (lat+1)-th cycle that a strobe is held.
    initial begin : responder
      int cnt;
      cnt = 0;
      auto_resp = 1'b0;
      forever begin
        @(posedge clk); #1;
        if (rst || !(mem_read[gi] || mem_write[gi])) cnt = 0;
        else cnt++;
        auto_resp = resp_en && (cnt == lat + 1);
      end
    end

    initial begin : monitor
      grant_t g;
      resp_t  r;
      logic   prev;
      int     run;
      prev = 1'b0;
      run  = 0;
      forever begin
        @(negedge clk);
        if (rst) begin
          prev = 1'b0;
          run  = 0;
        end else begin
          if ((mem_read[gi] || mem_write[gi]) && !prev) begin
            if (exp_grant.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_grant: got grant lane=%0d addr=%h, required none", gi, mem_address[gi]);
            end else begin
              g = exp_grant.pop_front();
              check("grant_lane", line_t'(gi), line_t'(g.lane));
              check("grant_addr", line_t'(mem_address[gi]), line_t'(g.addr));
              check("grant_write", line_t'(mem_write[gi]), line_t'(g.we));
              check("grant_read", line_t'(mem_read[gi]), line_t'(!g.we));
              if (g.we) check("grant_wdata", mem_wdata[gi], g.wdata);
            end
          end
          prev = mem_read[gi] || mem_write[gi];
          run  = prev ? run + 1 : 0;
          if (icache_resp[gi] || dcache_resp[gi]) begin
            if (exp_resp.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_resp: got i=%0b d=%0b lane=%0d, required none",
                       icache_resp[gi], dcache_resp[gi], gi);
            end else begin
              r = exp_resp.pop_front();
              $display("txn lane=%0d %s addr=%h strobe_cycles=%0d", gi, r.is_d ? "D" : "I",
                       mem_address[gi], run);
              check("resp_lane", line_t'(gi), line_t'(r.lane));
              check("resp_i", line_t'(icache_resp[gi]), line_t'(!r.is_d));
              check("resp_d", line_t'(dcache_resp[gi]), line_t'(r.is_d));
              check("resp_data", r.is_d ? dcache_rdata[gi] : icache_rdata[gi], r.data);
              check("resp_cycle", line_t'(run), line_t'(r.cycles));
            end
          end
        end
      end
    end
  end

  task automatic run_i(input int l, input logic [AW-1:0] a);
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    icache_read[l] = 1'b1;
    icache_address[l] = a;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (icache_resp[l]) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL i_timeout: got no icache_resp lane=%0d addr=%h, required one", l, a);
    end
    @(posedge clk); #1;
    icache_read[l] = 1'b0;
  endtask

  task automatic run_d(input int l, input logic [AW-1:0] a, input logic rd, input logic wr, input line_t wd);
    bit done;
    done = 1'b0;
    @(posedge clk); #1;
    dcache_read[l] = rd;
    dcache_write[l] = wr;
    dcache_address[l] = a;
    dcache_wdata[l] = wd;
    for (int c = 0; c < 100 && !done; c++) begin
      @(negedge clk);
      if (dcache_resp[l]) done = 1'b1;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL d_timeout: got no dcache_resp lane=%0d addr=%h, required one", l, a);
    end
    @(posedge clk); #1;
    dcache_read[l] = 1'b0;
    dcache_write[l] = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no finish, required finish before 200us");
    $fatal(1);
  end

  initial begin : stimulus
    int nd;
    bit seen;
    logic [AW-1:0] a_d;
    rst = 1'b1;
    icache_read = '0; dcache_read = '0; dcache_write = '0; manual_resp = '0;
    for (int l = 0; l < 2; l++) begin
      icache_address[l] = '0; dcache_address[l] = '0; dcache_wdata[l] = '0;
    end
    mem_rdata = '0;
    resp_en = 1'b1;
    lat = 3;
    repeat (2) @(negedge clk);
    for (int l = 0; l < 2; l++) begin
      check("rst_mem_read", line_t'(mem_read[l]), '0);
      check("rst_mem_write", line_t'(mem_write[l]), '0);
      check("rst_mem_address", line_t'(mem_address[l]), '0);
      check("rst_mem_wdata", mem_wdata[l], '0);
      check("rst_i_grants", line_t'(icache_grants[l]), '0);
      check("rst_d_grants", line_t'(dcache_grants[l]), '0);
    end
    rst = 1'b0;

    // 1: I read, L2 answers on the 4th strobe cycle.
    lat = 3;
    mem_rdata = {32{8'hA5}};
    exp_g(0, 1'b0, 32'h0000_0060, '0);
    exp_r(0, 1'b0, 4, {32{8'hA5}});
    run_i(0, 32'h0000_0060);
    check("t1_i_grants", line_t'(icache_grants[0]), line_t'(32'd1));
    check("t1_d_grants", line_t'(dcache_grants[0]), '0);

    // 2: simultaneous I and D from reset; round-robin picks I first.
    do_reset();
    lat = 2;
    mem_rdata = {8{32'h1234_5678}};
    exp_g(0, 1'b0, 32'h100, '0);
    exp_g(0, 1'b0, 32'h200, '0);
    exp_r(0, 1'b0, 3, {8{32'h1234_5678}});
    exp_r(0, 1'b1, 3, {8{32'h1234_5678}});
    fork
      run_i(0, 32'h100);
      run_d(0, 32'h200, 1'b1, 1'b0, '0);
    join
    check("t2_i_grants", line_t'(icache_grants[0]), line_t'(32'd1));
    check("t2_d_grants", line_t'(dcache_grants[0]), line_t'(32'd1));

    // 3: D writeback.
    lat = 2;
    mem_rdata = {4{64'h0F0F_0000_FFFF_0001}};
    exp_g(0, 1'b1, 32'h1000, line_t'(32'hDEAD_BEEF));
    exp_r(0, 1'b1, 3, {4{64'h0F0F_0000_FFFF_0001}});
    run_d(0, 32'h1000, 1'b0, 1'b1, line_t'(32'hDEAD_BEEF));
    check("t3_d_grants", line_t'(dcache_grants[0]), line_t'(32'd2));

    // 6: stray mem_resp in IDLE, then a read+write collision.
    @(posedge clk); #1;
    manual_resp[0] = 1'b1;
    @(negedge clk);
    check("t6_stray_i_resp", line_t'(icache_resp[0]), '0);
    check("t6_stray_d_resp", line_t'(dcache_resp[0]), '0);
    @(posedge clk); #1;
    manual_resp[0] = 1'b0;
    @(negedge clk);
    check("t6_stray_no_strobe", line_t'(mem_read[0] | mem_write[0]), '0);
    lat = 1;
    exp_g(0, 1'b1, 32'h300, line_t'(32'h0000_ABCD));
    exp_r(0, 1'b1, 2, {4{64'h0F0F_0000_FFFF_0001}});
    run_d(0, 32'h300, 1'b1, 1'b1, line_t'(32'h0000_ABCD));

    // 4: fixed priority lane; D held across three transactions starves I.
    lat = 1;
    mem_rdata = {16{16'hC3C3}};
    exp_g(1, 1'b0, 32'h500, '0);
    exp_g(1, 1'b0, 32'h540, '0);
    exp_g(1, 1'b0, 32'h580, '0);
    exp_g(1, 1'b0, 32'h400, '0);
    for (int k = 0; k < 3; k++) exp_r(1, 1'b1, 2, {16{16'hC3C3}});
    exp_r(1, 1'b0, 2, {16{16'hC3C3}});
    fork
      run_i(1, 32'h400);
      begin
        nd = 0;
        a_d = 32'h500;
        @(posedge clk); #1;
        dcache_read[1] = 1'b1;
        dcache_address[1] = a_d;
        for (int c = 0; c < 100 && nd < 3; c++) begin
          @(negedge clk);
          if (dcache_resp[1]) begin
            nd++;
            if (nd == 3) begin
              check("t4_i_grants_starved", line_t'(icache_grants[1]), '0);
              check("t4_d_grants", line_t'(dcache_grants[1]), line_t'(32'd3));
            end
            @(posedge clk); #1;
            a_d = a_d + 32'h40;
            dcache_address[1] = a_d;
          end
        end
        if (nd < 3) begin
          checks++; errors++;
          $display("FAIL t4_timeout: got %0d D responses, required 3", nd);
        end
        dcache_read[1] = 1'b0;
      end
    join
    check("t4_i_grants_final", line_t'(icache_grants[1]), line_t'(32'd1));

    // 5: reset while a write is in flight, then a late mem_resp.
    resp_en = 1'b0;
    exp_g(0, 1'b1, 32'h700, line_t'(32'h55));
    @(posedge clk); #1;
    dcache_write[0] = 1'b1;
    dcache_address[0] = 32'h700;
    dcache_wdata[0] = line_t'(32'h55);
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (mem_write[0]) seen = 1'b1;
    end
    check("t5_write_started", line_t'(seen), line_t'(1'b1));
    @(posedge clk); #1;
    rst = 1'b1;
    dcache_write[0] = 1'b0;
    #1;
    check("t5_write_drop", line_t'(mem_write[0]), '0);
    check("t5_read_drop", line_t'(mem_read[0]), '0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    manual_resp[0] = 1'b1;
    @(negedge clk);
    check("t5_late_d_resp", line_t'(dcache_resp[0]), '0);
    check("t5_late_i_resp", line_t'(icache_resp[0]), '0);
    @(posedge clk); #1;
    manual_resp[0] = 1'b0;
    @(negedge clk);
    check("t5_idle_strobes", line_t'(mem_read[0] | mem_write[0]), '0);
    check("t5_i_grants", line_t'(icache_grants[0]), '0);
    check("t5_d_grants", line_t'(dcache_grants[0]), '0);
    check("t5_mem_address", line_t'(mem_address[0]), '0);
    resp_en = 1'b1;

    repeat (3) @(negedge clk);
    check("left_grants", line_t'(exp_grant.size()), '0);
    check("left_resps", line_t'(exp_resp.size()), '0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
